// File: rtl/llc_port_arbiter_pkg.sv
// Shared state encoding and default geometry for the LLC port arbiter.
// Build option LLC_ARB_ROUND_ROBIN_EN (see llc_port_arbiter.sv) does not affect this package.
package llc_port_arbiter_pkg;

    localparam int ARB_NUM_PORTS = 2;
    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_LINE_W    = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/llc_port_arbiter_if.sv
// Upstream (L1 requesters) and downstream (L2 port) line-transfer bundle.
// slave is the arbiter side, master is the requester/memory side.
interface llc_port_arbiter_if
    import llc_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int LINE_W    = ARB_LINE_W
);

    logic [NUM_PORTS-1:0]             up_read;
    logic [NUM_PORTS-1:0]             up_write;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] up_addr;
    logic [NUM_PORTS-1:0][LINE_W-1:0] up_wdata;
    logic [LINE_W-1:0]                up_rdata;
    logic [NUM_PORTS-1:0]             up_resp;

    logic                             dn_read;
    logic                             dn_write;
    logic [ADDR_W-1:0]                dn_addr;
    logic [LINE_W-1:0]                dn_wdata;
    logic [LINE_W-1:0]                dn_rdata;
    logic                             dn_resp;

    modport slave (
        input  up_read, up_write, up_addr, up_wdata, dn_rdata, dn_resp,
        output up_rdata, up_resp, dn_read, dn_write, dn_addr, dn_wdata
    );

    modport master (
        output up_read, up_write, up_addr, up_wdata, dn_rdata, dn_resp,
        input  up_rdata, up_resp, dn_read, dn_write, dn_addr, dn_wdata
    );

endinterface

// File: rtl/llc_port_arbiter_rr_pick.sv
// Combinational winner selection: scan upward from a start index with wrap-around.
// LLC_ARB_ROUND_ROBIN_EN starts the scan at ptr_i; otherwise at port 0 (fixed priority).
module llc_port_arbiter_rr_pick
    import llc_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
`ifdef LLC_ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]     ptr_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 vld_o
);

    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   cand;
    logic             found;

`ifdef LLC_ARB_ROUND_ROBIN_EN
    assign start = ptr_i;
`else
    assign start = '0;
`endif

    // One extra bit on cand keeps start+i from overflowing before the wrap.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, start} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
                cand = cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                       = 1'b1;
                gnt_oh_o[cand[IDX_W-1:0]]   = 1'b1;
                gnt_idx_o                   = cand[IDX_W-1:0];
            end
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/llc_port_arbiter.sv
// N-port line-transfer arbiter in front of the single L2 port (IDLE -> BUSY -> RESP).
// Define LLC_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module llc_port_arbiter
    import llc_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int LINE_W    = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    llc_port_arbiter_if.slave arb_if
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 dn_read_q, dn_read_d;
    logic                 dn_write_q, dn_write_d;
    logic [ADDR_W-1:0]    dn_addr_q, dn_addr_d;
    logic [LINE_W-1:0]    dn_wdata_q, dn_wdata_d;
    logic [LINE_W-1:0]    rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] resp_q, resp_d;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 pick_wr;

`ifdef LLC_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    assign req     = arb_if.up_read | arb_if.up_write;
    // Read+write together is illegal; the write bit wins.
    assign pick_wr = |(pick_oh & arb_if.up_write);

    llc_port_arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i     (req),
`ifdef LLC_ARB_ROUND_ROBIN_EN
        .ptr_i     (ptr_q),
`endif
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .vld_o     (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        dn_read_d  = dn_read_q;
        dn_write_d = dn_write_q;
        dn_addr_d  = dn_addr_q;
        dn_wdata_d = dn_wdata_q;
        rdata_d    = rdata_q;
        resp_d     = '0;
`ifdef LLC_ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d    = ARB_BUSY;
                    grant_d    = pick_idx;
                    dn_addr_d  = arb_if.up_addr[pick_idx];
                    dn_wdata_d = arb_if.up_wdata[pick_idx];
                    dn_write_d = pick_wr;
                    dn_read_d  = !pick_wr;
                end
            end
            ARB_BUSY: begin
                if (arb_if.dn_resp) begin
                    state_d          = ARB_RESP;
                    rdata_d          = arb_if.dn_rdata;
                    dn_read_d        = 1'b0;
                    dn_write_d       = 1'b0;
                    resp_d[grant_q]  = 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
`ifdef LLC_ARB_ROUND_ROBIN_EN
                ptr_d   = (grant_q == IDX_W'(NUM_PORTS-1)) ? '0 : grant_q + 1'b1;
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            dn_read_q  <= 1'b0;
            dn_write_q <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            dn_read_q  <= dn_read_d;
            dn_write_q <= dn_write_d;
            dn_addr_q  <= dn_addr_d;
            dn_wdata_q <= dn_wdata_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

`ifdef LLC_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign arb_if.dn_read  = dn_read_q;
    assign arb_if.dn_write = dn_write_q;
    assign arb_if.dn_addr  = dn_addr_q;
    assign arb_if.dn_wdata = dn_wdata_q;
    assign arb_if.up_rdata = rdata_q;
    assign arb_if.up_resp  = resp_q;

endmodule

// File: tb/tb_llc_port_arbiter.sv
// Bench for llc_port_arbiter (4 ports): scoreboard of expected completions checked on up_resp.
// Expectations follow LLC_ARB_ROUND_ROBIN_EN when it is defined, fixed priority otherwise.
module tb_llc_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    llc_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) bus ();

    llc_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    typedef struct {
        int          port;
        bit          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   resp_cnt = 0;

    int            dn_lat   = 2;
    bit            use_fix  = 1'b0;
    logic [LW-1:0] fix_line = '0;

    logic          cap_wr, cap_rd, hold_ok, aborted;
    logic [AW-1:0] cap_addr;
    logic [LW-1:0] cap_wdata;

    function automatic logic [LW-1:0] rsp_line(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0F0F}};
    endfunction

    function automatic exp_t mk_exp(input int p, input bit wr, input logic [AW-1:0] a,
                                    input logic [LW-1:0] wd, input logic [LW-1:0] rd);
        exp_t e;
        e.port = p; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
        return e;
    endfunction

    // Downstream memory model: answers after dn_lat cycles, tracks that the request stays stable.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (rst_n && (bus.dn_read || bus.dn_write)) begin
                cap_wr = bus.dn_write; cap_rd = bus.dn_read;
                cap_addr = bus.dn_addr; cap_wdata = bus.dn_wdata;
                hold_ok = 1'b1; aborted = 1'b0;
                for (int i = 1; i < dn_lat; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else if (bus.dn_write !== cap_wr || bus.dn_read !== cap_rd ||
                             bus.dn_addr !== cap_addr || bus.dn_wdata !== cap_wdata) hold_ok = 1'b0;
                end
                if (!aborted && rst_n) begin
                    bus.dn_rdata = use_fix ? fix_line : rsp_line(cap_addr);
                    bus.dn_resp  = 1'b1;
                    @(negedge clk);
                    bus.dn_resp  = 1'b0;
                end
            end
        end
    end

    exp_t          m_e;
    logic [NP-1:0] m_oh;

    // Scoreboard: every up_resp pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && bus.up_resp !== '0) begin
            resp_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: got up_resp=%b, expected no completion", bus.up_resp);
            end else begin
                m_e  = exp_q.pop_front();
                m_oh = '0;
                m_oh[m_e.port] = 1'b1;
                if (bus.up_resp !== m_oh) begin
                    n_fail++;
                    $display("FAIL resp_port: got up_resp=%b, expected %b", bus.up_resp, m_oh);
                end
                n_checks++;
                if (cap_wr !== m_e.wr || cap_rd !== !m_e.wr) begin
                    n_fail++;
                    $display("FAIL dn_dir: got rd=%b wr=%b, expected wr=%b", cap_rd, cap_wr, m_e.wr);
                end
                n_checks++;
                if (cap_addr !== m_e.addr) begin
                    n_fail++;
                    $display("FAIL dn_addr: got %h, expected %h", cap_addr, m_e.addr);
                end
                n_checks++;
                if (hold_ok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dn_hold: got hold_ok=%b, expected 1", hold_ok);
                end
                n_checks++;
                if (m_e.wr && cap_wdata !== m_e.wdata) begin
                    n_fail++;
                    $display("FAIL dn_wdata: got %h, expected %h", cap_wdata, m_e.wdata);
                end else if (!m_e.wr && bus.up_rdata !== m_e.rdata) begin
                    n_fail++;
                    $display("FAIL up_rdata: got %h, expected %h", bus.up_rdata, m_e.rdata);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus.dn_read !== 1'b0 || bus.dn_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dn_ctrl: got rd=%b wr=%b, expected 0 0", bus.dn_read, bus.dn_write);
        end
        n_checks++;
        if (bus.up_resp !== '0) begin
            n_fail++;
            $display("FAIL reset_up_resp: got %b, expected 0", bus.up_resp);
        end
        n_checks++;
        if (bus.dn_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_dn_addr: got %h, expected 0", bus.dn_addr);
        end
        n_checks++;
        if (bus.dn_wdata !== '0 || bus.up_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got wdata=%h rdata=%h, expected 0", bus.dn_wdata, bus.up_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_single_read();
        int tgt;
        tgt      = resp_cnt + 1;
        dn_lat   = 4;
        use_fix  = 1'b1;
        fix_line = {32{8'hA5}};
        exp_q.push_back(mk_exp(1, 1'b0, 32'h0000_1000, '0, {32{8'hA5}}));
        bus.up_addr[1] = 32'h0000_1000;
        bus.up_read[1] = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.dn_read !== 1'b1 || bus.dn_addr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL read_latency: got dn_read=%b dn_addr=%h, expected 1 00001000", bus.dn_read, bus.dn_addr);
        end
        for (int i = 0; i < 40 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL read_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        bus.up_read[1] = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (bus.up_resp !== '0) begin
            n_fail++;
            $display("FAIL read_resp_width: got up_resp=%b one cycle later, expected 0", bus.up_resp);
        end
        use_fix = 1'b0;
    endtask

    task automatic test_fairness();
        int tgt;
        int ord[4];
`ifdef LLC_ARB_ROUND_ROBIN_EN
        ord = '{0, 1, 0, 1};
`else
        ord = '{0, 0, 0, 0};
`endif
        dn_lat = 2;
        tgt    = resp_cnt + 4;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk_exp(ord[k], 1'b0, 32'h100 * (ord[k] + 1), '0,
                                   rsp_line(32'h100 * (ord[k] + 1))));
        end
        bus.up_addr[0] = 32'h100;
        bus.up_addr[1] = 32'h200;
        bus.up_read[1:0] = 2'b11;
        for (int i = 0; i < 80 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        bus.up_read[1:0] = 2'b00;
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL fairness_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_write();
        int tgt;
        tgt    = resp_cnt + 1;
        dn_lat = 3;
        exp_q.push_back(mk_exp(2, 1'b1, 32'h0000_2000, {8{32'hDEAD_BEEF}}, '0));
        bus.up_addr[2]  = 32'h0000_2000;
        bus.up_wdata[2] = {8{32'hDEAD_BEEF}};
        bus.up_write[2] = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.dn_write !== 1'b1 || bus.dn_read !== 1'b0 || bus.dn_wdata !== {8{32'hDEAD_BEEF}}) begin
            n_fail++;
            $display("FAIL write_start: got wr=%b rd=%b wdata=%h, expected 1 0 DEADBEEF..", bus.dn_write, bus.dn_read, bus.dn_wdata);
        end
        for (int i = 0; i < 40 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        bus.up_write[2] = 1'b0;
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL write_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int tgt;
        int second;
`ifdef LLC_ARB_ROUND_ROBIN_EN
        second = 1;
`else
        second = 0;
`endif
        dn_lat = 2;
        tgt    = resp_cnt + 1;
        exp_q.push_back(mk_exp(0, 1'b0, 32'h300, '0, rsp_line(32'h300)));
        bus.up_addr[0] = 32'h300;
        bus.up_addr[2] = 32'h2400;
        bus.up_read[0] = 1'b1;
        bus.up_read[2] = 1'b1;
        for (int i = 0; i < 40 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        bus.up_read[2] = 1'b0;
        bus.up_addr[1] = 32'h1100;
        exp_q.push_back(mk_exp(second, 1'b0, second == 1 ? 32'h1100 : 32'h300, '0,
                               rsp_line(second == 1 ? 32'h1100 : 32'h300)));
        bus.up_read[1] = 1'b1;
        tgt = resp_cnt + 1;
        for (int i = 0; i < 40 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        bus.up_read[1:0] = 2'b00;
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL wrap_ptr_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_drop_busy();
        int tgt;
        dn_lat = 5;
        tgt    = resp_cnt + 1;
        exp_q.push_back(mk_exp(3, 1'b0, 32'h3000, '0, rsp_line(32'h3000)));
        bus.up_addr[3] = 32'h3000;
        bus.up_read[3] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        bus.up_read[3] = 1'b0;
        for (int i = 0; i < 40 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL drop_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (resp_cnt !== tgt || bus.dn_read !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_once: got %0d completions dn_read=%b, expected %0d and 0", resp_cnt, bus.dn_read, tgt);
        end
    endtask

    task automatic test_both_rw();
        int tgt;
        dn_lat = 2;
        tgt    = resp_cnt + 1;
        exp_q.push_back(mk_exp(1, 1'b1, 32'h4000, {8{32'h1234_5678}}, '0));
        bus.up_addr[1]  = 32'h4000;
        bus.up_wdata[1] = {8{32'h1234_5678}};
        bus.up_read[1]  = 1'b1;
        bus.up_write[1] = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.dn_write !== 1'b1 || bus.dn_read !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_as_write: got rd=%b wr=%b, expected 0 1", bus.dn_read, bus.dn_write);
        end
        for (int i = 0; i < 40 && resp_cnt < tgt; i++) begin @(negedge clk); #1; end
        bus.up_read[1]  = 1'b0;
        bus.up_write[1] = 1'b0;
        n_checks++;
        if (resp_cnt < tgt) begin
            n_fail++;
            $display("FAIL rw_timeout: got %0d completions, expected %0d", resp_cnt, tgt);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int snap;
        dn_lat = 6;
        bus.up_addr[0] = 32'h5000;
        bus.up_read[0] = 1'b1;
        for (int i = 0; i < 10 && bus.dn_read !== 1'b1; i++) begin @(negedge clk); #1; end
        n_checks++;
        if (bus.dn_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_start: got dn_read=%b, expected 1", bus.dn_read);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.dn_read !== 1'b0 || bus.dn_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got rd=%b wr=%b, expected 0 0", bus.dn_read, bus.dn_write);
        end
        bus.up_read[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap  = resp_cnt;
        @(negedge clk); #1;
        bus.dn_resp = 1'b1;
        @(negedge clk); #1;
        bus.dn_resp = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        n_checks++;
        if (resp_cnt !== snap || bus.dn_read !== 1'b0 || bus.dn_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d completions rd=%b wr=%b, expected %0d 0 0", resp_cnt, bus.dn_read, bus.dn_write, snap);
        end
    endtask

    initial begin : main
        bus.up_read  = '0;
        bus.up_write = '0;
        bus.up_addr  = '0;
        bus.up_wdata = '0;
        bus.dn_resp  = 1'b0;
        bus.dn_rdata = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write();
        test_wrap();
        test_drop_busy();
        test_both_rw();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding completions, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
